verifier_compute_chi: RTL and testbench

VERIFIER_COMPUTE_CHI -- requirements
Module: verifier_compute_chi

---
 rtl/verifier_compute_chi.sv | 190 +++++++++++++++++++
 tb/tb_verifier_compute_chi.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/verifier_compute_chi.sv
// Builds the multilinear chi table for point tau over GF(2^61-1) in place, then streams it out
// one (index, value) beat per cycle with a valid/ready handshake.
module verifier_compute_chi #(
  parameter int nValBits = 8,
  parameter int nValues  = 1 << nValBits,
  localparam int F_NBITS = 61
) (
  input  logic                              clk,
  input  logic                              rstb,
  input  logic                              en,
  input  logic [nValBits-1:0][F_NBITS-1:0]  tau,
  output logic [F_NBITS-1:0]                out_data,
  output logic [nValBits-1:0]               out_idx,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last,
  output logic                              ready
);

  if (nValBits < 2) begin : g_bad_bits
    $error("verifier_compute_chi: nValBits must be at least 2");
  end
  if (nValues != (1 << nValBits)) begin : g_bad_values
    $error("verifier_compute_chi: nValues must equal 1 << nValBits");
  end

  localparam int JW = $clog2(nValBits);
  localparam logic [F_NBITS-1:0] F_Q_P = {F_NBITS{1'b1}};
  // ~t + (p + 2 - 2^F_NBITS) == 1 - t (mod p); for a Mersenne prime the offset is 1.
  localparam logic [F_NBITS-1:0] F_Q_P2_MI = F_NBITS'(1);
  localparam logic [F_NBITS-1:0] F_ONE = F_NBITS'(1);

  typedef enum logic [2:0] {ST_IDLE, ST_SUB, ST_MUL_HI, ST_MUL_LO, ST_STREAM} state_t;

  function automatic logic [F_NBITS-1:0] f_add(input logic [F_NBITS-1:0] a,
                                               input logic [F_NBITS-1:0] b);
    logic [F_NBITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, F_Q_P}) s = s - {1'b0, F_Q_P};
    return s[F_NBITS-1:0];
  endfunction

  // Mersenne reduction: fold the high half onto the low half twice, then one conditional subtract.
  function automatic logic [F_NBITS-1:0] f_mul(input logic [F_NBITS-1:0] a,
                                               input logic [F_NBITS-1:0] b);
    logic [2*F_NBITS-1:0] prod;
    logic [F_NBITS:0]     s;
    logic [F_NBITS:0]     t;
    prod = {{F_NBITS{1'b0}}, a} * {{F_NBITS{1'b0}}, b};
    s = {1'b0, prod[F_NBITS-1:0]} + {1'b0, prod[2*F_NBITS-1:F_NBITS]};
    t = {1'b0, s[F_NBITS-1:0]} + {{F_NBITS{1'b0}}, s[F_NBITS]};
    if (t >= {1'b0, F_Q_P}) t = t - {1'b0, F_Q_P};
    return t[F_NBITS-1:0];
  endfunction

  state_t                             state;
  logic                               en_dly;
  logic                               start;
  logic [JW-1:0]                      j;
  logic [nValBits-1:0]                k;
  logic [nValBits-1:0]                idx;
  logic [nValBits-1:0][F_NBITS-1:0]   tau_q;
  logic [F_NBITS-1:0]                 m_q;
  logic [F_NBITS-1:0]                 table_q [nValues];

  // Field adder: registered, one-cycle latency, en/ready handshake.
  logic                               add_en_q;
  logic                               add_pend;
  logic                               add_rdy_q;
  logic [F_NBITS-1:0]                 add_res_q;

  // Field multiplier: combinational, one operation per MUL_HI/MUL_LO cycle.
  logic                               mul_en;
  logic [F_NBITS-1:0]                 mul_b;
  logic [F_NBITS-1:0]                 mul_res;

  logic [F_NBITS-1:0]                 tau_j;
  logic [nValBits-1:0]                pow_j;
  logic [nValBits-1:0]                hi_idx;
  logic [nValBits-1:0]                k_last;
  logic [nValBits-1:0]                idx_nxt;

  assign start   = en & ~en_dly;
  assign ready   = (state == ST_IDLE) & ~start;
  assign out_idx = idx;

  assign tau_j   = tau_q[j];
  assign pow_j   = nValBits'(1) << j;
  assign hi_idx  = k | pow_j;
  assign k_last  = pow_j - nValBits'(1);
  assign idx_nxt = idx + nValBits'(1);

  assign mul_en  = (state == ST_MUL_HI) || (state == ST_MUL_LO);
  assign mul_b   = (state == ST_MUL_HI) ? tau_j : m_q;
  assign mul_res = f_mul(table_q[k], mul_b);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      add_rdy_q <= 1'b0;
      add_res_q <= '0;
    end else begin
      add_rdy_q <= add_en_q;
      if (add_en_q) add_res_q <= f_add(~tau_j, F_Q_P2_MI);
    end
  end

  // HI reads table[k] before LO overwrites it, so the split step is in-place safe.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start) begin
      table_q[0] <= F_ONE;
    end else if (state == ST_MUL_HI) begin
      table_q[hi_idx] <= mul_res;
    end else if (state == ST_MUL_LO) begin
      table_q[k] <= mul_res;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state     <= ST_IDLE;
      en_dly    <= 1'b1;
      j         <= '0;
      k         <= '0;
      idx       <= '0;
      tau_q     <= '0;
      m_q       <= '0;
      add_en_q  <= 1'b0;
      add_pend  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      en_dly   <= en;
      add_en_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            tau_q <= tau;
            j     <= '0;
            state <= ST_SUB;
          end
        end
        ST_SUB: begin
          if (!add_pend) begin
            add_en_q <= 1'b1;
            add_pend <= 1'b1;
          end else if (add_rdy_q) begin
            m_q      <= add_res_q;
            add_pend <= 1'b0;
            k        <= '0;
            state    <= ST_MUL_HI;
          end
        end
        ST_MUL_HI: state <= ST_MUL_LO;
        ST_MUL_LO: begin
          if (k != k_last) begin
            k     <= k + nValBits'(1);
            state <= ST_MUL_HI;
          end else if (j != JW'(nValBits - 1)) begin
            j     <= j + JW'(1);
            state <= ST_SUB;
          end else begin
            // The last LO write targets a nonzero index, so table[0] is already final here.
            idx       <= '0;
            out_data  <= table_q[0];
            out_last  <= 1'b0;
            out_valid <= 1'b1;
            state     <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (out_valid && out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              idx       <= '0;
              state     <= ST_IDLE;
            end else begin
              idx      <= idx_nxt;
              out_data <= table_q[idx_nxt];
              out_last <= (idx_nxt == nValBits'(nValues - 1));
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_verifier_compute_chi.sv
// Directed bench for verifier_compute_chi: a 2-bit instance for hand-computed vectors and an
// 8-bit instance checked against a modulo-arithmetic reference model.
module tb_verifier_compute_chi;

  localparam logic [60:0] P = 61'h1FFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rstb;
  always #5 clk = ~clk;

  logic              en2, or2, v2, l2, r2;
  logic [1:0][60:0]  tau2;
  logic [60:0]       d2;
  logic [1:0]        i2;

  logic              en8, or8, v8, l8, r8;
  logic [7:0][60:0]  tau8;
  logic [60:0]       d8;
  logic [7:0]        i8;

  int vectors = 0;
  int miscompares = 0;
  int add_cnt = 0;
  int mul_cnt = 0;

  verifier_compute_chi #(.nValBits(2)) u_dut2 (
    .clk(clk), .rstb(rstb), .en(en2), .tau(tau2), .out_data(d2), .out_idx(i2),
    .out_valid(v2), .out_ready(or2), .out_last(l2), .ready(r2)
  );

  verifier_compute_chi #(.nValBits(8)) u_dut8 (
    .clk(clk), .rstb(rstb), .en(en8), .tau(tau8), .out_data(d8), .out_idx(i8),
    .out_valid(v8), .out_ready(or8), .out_last(l8), .ready(r8)
  );

  always @(posedge clk) begin
    if (u_dut8.add_en_q) add_cnt++;
    if (u_dut8.mul_en) mul_cnt++;
  end

  function automatic logic [60:0] mmul(input logic [60:0] a, input logic [60:0] b);
    logic [127:0] t;
    t = {67'b0, a} * {67'b0, b};
    return 61'(t % {67'b0, P});
  endfunction

  function automatic logic [60:0] one_minus(input logic [60:0] a);
    logic [127:0] x;
    x = {67'b0, P} + 128'd1 - {67'b0, a};
    return 61'(x % {67'b0, P});
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_v2(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (v2) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic pulse_en2;
    en2 = 1'b1;
    step();
    en2 = 1'b0;
  endtask

  task automatic test_reset;
    rstb = 1'b0;
    en2 = 1'b0; or2 = 1'b0; tau2 = '0;
    en8 = 1'b0; or8 = 1'b0; tau8 = '0;
    #12;
    vectors++;
    if (v2 !== 1'b0 || l2 !== 1'b0 || i2 !== 2'd0 || d2 !== 61'd0 || v8 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%b l=%b idx=%0d data=%0h v8=%b want 0 0 0 0 0",
               v2, l2, i2, d2, v8);
    end
    step();
    rstb = 1'b1;
    step(); step();
    vectors++;
    if (r2 !== 1'b1 || r8 !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got r2=%b r8=%b want 1 1", r2, r8);
    end
  endtask

  task automatic test_basic;
    logic [60:0] exp [4];
    bit ok;
    exp = '{61'd2, P - 61'd4, P - 61'd3, 61'd6};
    tau2 = {61'd3, 61'd2};
    or2 = 1'b1;
    pulse_en2();
    for (int b = 0; b < 4; b++) begin
      wait_v2(ok);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL basic_timeout: got no valid want beat %0d", b);
        break;
      end
      vectors++;
      if (d2 !== exp[b] || i2 !== 2'(b) || l2 !== (b == 3)) begin
        miscompares++;
        $display("FAIL basic_beat%0d: got idx=%0d data=%0h last=%b want idx=%0d data=%0h last=%b",
                 b, i2, d2, l2, b, exp[b], (b == 3));
      end
      step();
    end
    vectors++;
    if (v2 !== 1'b0 || r2 !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_done: got valid=%b ready=%b want 0 1", v2, r2);
    end
  endtask

  task automatic test_corners;
    logic [60:0] exp [2][4];
    logic [60:0] tv [2];
    bit ok;
    exp = '{'{61'd1, 61'd0, 61'd0, 61'd0}, '{61'd0, 61'd0, 61'd0, 61'd1}};
    tv = '{61'd0, 61'd1};
    or2 = 1'b1;
    for (int v = 0; v < 2; v++) begin
      tau2 = {tv[v], tv[v]};
      pulse_en2();
      for (int b = 0; b < 4; b++) begin
        wait_v2(ok);
        vectors++;
        if (!ok || d2 !== exp[v][b] || i2 !== 2'(b)) begin
          miscompares++;
          $display("FAIL corner_tau%0d_beat%0d: got valid=%b idx=%0d data=%0h want idx=%0d data=%0h",
                   tv[v], b, ok, i2, d2, b, exp[v][b]);
        end
        step();
      end
    end
  endtask

  task automatic test_stall;
    logic [60:0] exp [4];
    logic [60:0] hd;
    logic [1:0]  hi;
    logic        hl;
    bit          held, first, rdy;
    int          got;
    exp = '{61'd2, P - 61'd4, P - 61'd3, 61'd6};
    tau2 = {61'd3, 61'd2};
    or2 = 1'b0;
    held = 1'b0; first = 1'b1; got = 0;
    pulse_en2();
    for (int c = 0; c < 400 && got < 4; c++) begin
      if (v2) begin
        if (held) begin
          vectors++;
          if (d2 !== hd || i2 !== hi || l2 !== hl) begin
            miscompares++;
            $display("FAIL stall_stable: got idx=%0d data=%0h last=%b want idx=%0d data=%0h last=%b",
                     i2, d2, l2, hi, hd, hl);
          end
        end
        rdy = first ? 1'b0 : 1'($urandom_range(0, 1));
        first = 1'b0;
        or2 = rdy;
        if (rdy) begin
          vectors++;
          if (d2 !== exp[got] || i2 !== 2'(got) || l2 !== (got == 3)) begin
            miscompares++;
            $display("FAIL stall_beat%0d: got idx=%0d data=%0h last=%b want idx=%0d data=%0h",
                     got, i2, d2, l2, got, exp[got]);
          end
          got++;
          held = 1'b0;
        end else begin
          hd = d2; hi = i2; hl = l2;
          held = 1'b1;
        end
      end
      step();
    end
    vectors++;
    if (got != 4 || v2 !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_count: got beats=%0d valid=%b want 4 0", got, v2);
    end
    or2 = 1'b1;
  endtask

  task automatic test_en_edge;
    logic [60:0] exp [4];
    int beats;
    exp = '{61'd2, P - 61'd4, P - 61'd3, 61'd6};
    or2 = 1'b1;
    tau2 = {61'd3, 61'd2};
    rstb = 1'b0;
    en2 = 1'b1;
    step();
    rstb = 1'b1;
    beats = 0;
    for (int c = 0; c < 10; c++) begin
      if (v2) beats++;
      step();
    end
    vectors++;
    if (beats != 0 || r2 !== 1'b1) begin
      miscompares++;
      $display("FAIL en_held_reset: got beats=%0d ready=%b want 0 1", beats, r2);
    end
    en2 = 1'b0;
    step();
    en2 = 1'b1;
    step();
    tau2 = {61'd9, 61'd9};
    step(); step();
    en2 = 1'b0;
    step();
    en2 = 1'b1;
    beats = 0;
    for (int c = 0; c < 100; c++) begin
      if (v2) begin
        if (beats < 4) begin
          vectors++;
          if (d2 !== exp[beats] || i2 !== 2'(beats)) begin
            miscompares++;
            $display("FAIL en_edge_beat%0d: got idx=%0d data=%0h want idx=%0d data=%0h",
                     beats, i2, d2, beats, exp[beats]);
          end
        end
        beats++;
      end
      step();
    end
    vectors++;
    if (beats != 4) begin
      miscompares++;
      $display("FAIL en_edge_count: got beats=%0d want 4", beats);
    end
    en2 = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_stream;
    logic [60:0] exp [4];
    bit ok;
    exp = '{61'd24, P - 61'd30, P - 61'd28, 61'd35};
    tau2 = {61'd7, 61'd5};
    or2 = 1'b1;
    pulse_en2();
    wait_v2(ok);
    vectors++;
    if (!ok || d2 !== exp[0] || i2 !== 2'd0) begin
      miscompares++;
      $display("FAIL abort_first: got valid=%b idx=%0d data=%0h want 1 0 %0h", ok, i2, d2, exp[0]);
    end
    step();
    vectors++;
    if (v2 !== 1'b1 || i2 !== 2'd1) begin
      miscompares++;
      $display("FAIL abort_idx1: got valid=%b idx=%0d want 1 1", v2, i2);
    end
    rstb = 1'b0;
    #1;
    vectors++;
    if (v2 !== 1'b0 || r2 !== 1'b1 || i2 !== 2'd0) begin
      miscompares++;
      $display("FAIL abort_reset: got valid=%b ready=%b idx=%0d want 0 1 0", v2, r2, i2);
    end
    #2;
    rstb = 1'b1;
    step(); step();
    pulse_en2();
    for (int b = 0; b < 4; b++) begin
      wait_v2(ok);
      vectors++;
      if (!ok || d2 !== exp[b] || i2 !== 2'(b) || l2 !== (b == 3)) begin
        miscompares++;
        $display("FAIL abort_rerun_beat%0d: got valid=%b idx=%0d data=%0h want idx=%0d data=%0h",
                 b, ok, i2, d2, b, exp[b]);
      end
      step();
    end
  endtask

  task automatic test_big;
    logic [60:0]  tv [8];
    logic [60:0]  model [256];
    logic [63:0]  r;
    logic [60:0]  acc;
    logic [127:0] s;
    bit           ok;
    for (int i = 0; i < 8; i++) begin
      r = {$urandom(), $urandom()};
      tv[i] = r[60:0];
      if (tv[i] >= P) tv[i] = tv[i] - P;
      tau8[i] = tv[i];
    end
    for (int b = 0; b < 256; b++) begin
      model[b] = 61'd1;
      for (int jj = 0; jj < 8; jj++)
        model[b] = mmul(model[b], ((b >> jj) & 1) != 0 ? tv[jj] : one_minus(tv[jj]));
    end
    or8 = 1'b1;
    add_cnt = 0;
    mul_cnt = 0;
    en8 = 1'b1;
    step();
    en8 = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (v8) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL big_timeout: got no valid want valid within 2000 cycles");
    end else begin
      acc = 61'd0;
      for (int b = 0; b < 256; b++) begin
        vectors++;
        if (v8 !== 1'b1 || d8 !== model[b] || i8 !== 8'(b) || l8 !== (b == 255)) begin
          miscompares++;
          $display("FAIL big_beat%0d: got valid=%b idx=%0d data=%0h last=%b want idx=%0d data=%0h",
                   b, v8, i8, d8, l8, b, model[b]);
        end
        s = ({67'b0, acc} + {67'b0, d8}) % {67'b0, P};
        acc = 61'(s);
        step();
      end
      vectors++;
      if (acc !== 61'd1) begin
        miscompares++;
        $display("FAIL big_sum: got %0h want 1", acc);
      end
    end
    vectors++;
    if (add_cnt != 8 || mul_cnt != 510) begin
      miscompares++;
      $display("FAIL big_op_counts: got add=%0d mul=%0d want 8 510", add_cnt, mul_cnt);
    end
    vectors++;
    if (r8 !== 1'b1 || v8 !== 1'b0) begin
      miscompares++;
      $display("FAIL big_done: got ready=%b valid=%b want 1 0", r8, v8);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_stall();
    test_en_edge();
    test_reset_mid_stream();
    test_big();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
